// File: rtl/merge_pkg.sv
// Shared types and helpers for the merge-path blocks.
//   ser_state_t : serializer FSM states (IDLE, SEND)
//   word_t      : one DW-bit data word
//   eff_len     : maps a requested vector length to the number of words sent
`include "params.svh"

package merge_pkg;

  typedef enum logic {IDLE, SEND} ser_state_t;

  typedef logic [`DW-1:0] word_t;

  // A length of 0, or one larger than the vector, means "send the full vector".
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned vn);
    return ((len == 0) || (len > vn)) ? vn : len;
  endfunction

endpackage

// File: rtl/params.svh
// Global word-width definition shared by the merge datapath.
//   DW : bits per data word (IEEE-754 single precision).
`ifndef PARAMS_SVH
`define PARAMS_SVH
`define DW 32
`endif

// File: rtl/merge_vec_serializer.sv
// Vector-to-word serializer feeding a merge router input port.
// Captures one vector of up to VN words and emits it word 0 first on a
// valid/ready stream. A new vector is accepted in the same cycle the last
// word handshakes, so consecutive vectors stream with no bubble.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   vec_data_i   : VN packed words, word i at [i*DW +: DW]
//   vec_len_i    : words to send (0 or > VN means VN)
//   vec_valid_i  : vector offered
//   vec_ready_o  : vector accepted when vec_valid_i & vec_ready_o
//   data_o       : current word (0 when idle)
//   valid_o      : word present
//   ready_i      : downstream can take a word
//   busy_o       : high while sending
//   vec_cnt_o    : completed-vector count, wraps modulo 2^CW
`include "params.svh"

module merge_vec_serializer
  import merge_pkg::*;
#(
  parameter int VN = 8,
  parameter int LW = $clog2(VN + 1),
  parameter int CW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [VN*`DW-1:0]   vec_data_i,
  input  logic [LW-1:0]       vec_len_i,
  input  logic                vec_valid_i,
  output logic                vec_ready_o,
  output logic [`DW-1:0]      data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                busy_o,
  output logic [CW-1:0]       vec_cnt_o
);

  localparam int HW = $clog2(VN * `DW);

  ser_state_t          state_reg;
  logic [VN*`DW-1:0]   hold_reg;
  logic [LW:0]         len_q_reg;
  logic [LW-1:0]       idx_reg;
  logic [CW-1:0]       vec_cnt_reg;

  logic                w_hs;
  logic                v_hs;
  logic                last;
  logic [LW:0]         len_eff;
  logic [HW-1:0]       word_base;

  assign valid_o   = (state_reg == SEND);
  assign busy_o    = valid_o;
  assign vec_cnt_o = vec_cnt_reg;

  assign w_hs = valid_o & ready_i;
  // len_q is 0 in IDLE, so len_q-1 is all ones there and last stays low.
  assign last = ({1'b0, idx_reg} == (len_q_reg - (LW+1)'(1)));

  // Combinational from ready_i on purpose: lets the next vector load in the
  // same cycle the final word leaves, so there is no gap between vectors.
  assign vec_ready_o = (state_reg == IDLE) | (w_hs & last);
  assign v_hs        = vec_valid_i & vec_ready_o;

  assign len_eff   = (LW+1)'(eff_len(32'(vec_len_i), VN));
  assign word_base = HW'(idx_reg) * HW'(`DW);
  assign data_o    = valid_o ? hold_reg[word_base +: `DW] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      hold_reg    <= '0;
      len_q_reg   <= '0;
      idx_reg     <= '0;
      vec_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (v_hs) begin
            hold_reg  <= vec_data_i;
            len_q_reg <= len_eff;
            idx_reg   <= '0;
            state_reg <= SEND;
          end
        end
        SEND: begin
          if (w_hs) begin
            if (!last) begin
              idx_reg <= idx_reg + LW'(1);
            end else begin
              vec_cnt_reg <= vec_cnt_reg + CW'(1);
              idx_reg     <= '0;
              if (v_hs) begin
                hold_reg  <= vec_data_i;
                len_q_reg <= len_eff;
              end else begin
                len_q_reg <= '0;
                state_reg <= IDLE;
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_merge_vec_serializer.sv
module tb_merge_vec_serializer;
  import merge_pkg::*;

  localparam int VN = 4;
  localparam int DW = $bits(word_t);
  localparam int LW = $clog2(VN + 1);
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [VN*DW-1:0]  vec_data = '0;
  logic [LW-1:0]     vec_len = '0;
  logic              vec_valid = 1'b0;
  logic              vec_ready;
  logic [DW-1:0]     data_o;
  logic              valid_o;
  logic              ready_i = 1'b0;
  logic              busy_o;
  logic [CW-1:0]     vec_cnt;

  merge_vec_serializer #(.VN(VN), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .vec_data_i  (vec_data),
    .vec_len_i   (vec_len),
    .vec_valid_i (vec_valid),
    .vec_ready_o (vec_ready),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .vec_cnt_o   (vec_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned exp_cnt = 0;

  typedef struct {
    string         name;
    logic [LW-1:0] len;
    word_t         w[4];
    int            exp_n;
  } vec_rec_t;

  vec_rec_t tbl[5];
  word_t    std_w[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic load_vec(input word_t w[4], input logic [LW-1:0] len);
    for (int i = 0; i < VN; i++) vec_data[i*DW +: DW] = w[i];
    vec_len = len;
  endtask

  // Called at posedge+1 with the block idle; samples at posedge+3.
  task automatic send_vec(input string name, input logic [LW-1:0] len,
                          input word_t w[4], input int exp_n);
    load_vec(w, len);
    vec_valid = 1'b1;
    ready_i   = 1'b1;
    #2 chk({name, " vec_ready idle"}, 64'(vec_ready), 64'd1);
    @(posedge clk); #1;
    vec_valid = 1'b0;
    vec_data  = '1;  // post-capture input changes must not reach the output
    for (int c = 0; c <= exp_n; c++) begin
      #2;
      if (c < exp_n) begin
        chk($sformatf("%s valid w%0d", name, c), 64'(valid_o), 64'd1);
        chk($sformatf("%s data w%0d", name, c), 64'(data_o), 64'(w[c]));
      end else begin
        chk($sformatf("%s valid end", name), 64'(valid_o), 64'd0);
      end
      @(posedge clk); #1;
    end
    exp_cnt = (exp_cnt + 1) % 65536;
    chk({name, " vec_cnt"}, 64'(vec_cnt), 64'(exp_cnt));
    chk({name, " busy end"}, 64'(busy_o), 64'd0);
  endtask

  task automatic set_rec(input int i, input string name, input logic [LW-1:0] len,
                         input word_t w0, input word_t w1, input word_t w2, input word_t w3,
                         input int exp_n);
    tbl[i].name  = name;
    tbl[i].len   = len;
    tbl[i].w[0]  = w0;
    tbl[i].w[1]  = w1;
    tbl[i].w[2]  = w2;
    tbl[i].w[3]  = w3;
    tbl[i].exp_n = exp_n;
  endtask

  initial begin
    word_t a_w[4];
    word_t b_w[4];
    word_t bp_exp[7];

    std_w = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    set_rec(0, "len4", 3'd4, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 4);
    set_rec(1, "len0", 3'd0, 32'hC0000000, 32'hBF800000, 32'h7F800000, 32'h00000001, 4);
    set_rec(2, "len1", 3'd1, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 1);
    set_rec(3, "len7", 3'd7, 32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hFFFFFFFF, 4);
    set_rec(4, "len3", 3'd3, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 3);

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk("reset valid", 64'(valid_o), 64'd0);
    chk("reset busy", 64'(busy_o), 64'd0);
    chk("reset data", 64'(data_o), 64'd0);
    chk("reset vec_cnt", 64'(vec_cnt), 64'd0);
    chk("reset vec_ready", 64'(vec_ready), 64'd1);
    @(posedge clk); #1 rst = 1'b0;

    // Table: single vectors, length clamping and single-word case
    for (int i = 0; i < 5; i++) send_vec(tbl[i].name, tbl[i].len, tbl[i].w, tbl[i].exp_n);

    // Back-to-back vectors: 8 valid cycles, no gap
    a_w = std_w;
    b_w = '{32'hAAAA0001, 32'hAAAA0002, 32'hAAAA0003, 32'hAAAA0004};
    load_vec(a_w, 3'd4);
    vec_valid = 1'b1;
    ready_i   = 1'b1;
    @(posedge clk); #1;
    load_vec(b_w, 3'd4);
    for (int k = 0; k < 8; k++) begin
      #2;
      chk($sformatf("b2b valid %0d", k), 64'(valid_o), 64'd1);
      chk($sformatf("b2b data %0d", k), 64'(data_o), 64'(k < 4 ? a_w[k] : b_w[k-4]));
      chk($sformatf("b2b vec_ready %0d", k), 64'(vec_ready), 64'((k == 3) || (k == 7)));
      @(posedge clk); #1;
      if (k == 3) vec_valid = 1'b0;
    end
    #2 chk("b2b valid end", 64'(valid_o), 64'd0);
    exp_cnt = (exp_cnt + 2) % 65536;
    chk("b2b vec_cnt", 64'(vec_cnt), 64'(exp_cnt));
    @(posedge clk); #1;

    // Backpressure: ready low in cycles 2-4
    bp_exp = '{std_w[0], std_w[1], std_w[1], std_w[1], std_w[1], std_w[2], std_w[3]};
    load_vec(std_w, 3'd4);
    vec_valid = 1'b1;
    ready_i   = 1'b1;
    @(posedge clk); #1;
    vec_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      ready_i = ((k + 1) >= 2 && (k + 1) <= 4) ? 1'b0 : 1'b1;
      #2;
      chk($sformatf("bp valid c%0d", k + 1), 64'(valid_o), 64'd1);
      chk($sformatf("bp data c%0d", k + 1), 64'(data_o), 64'(bp_exp[k]));
      chk($sformatf("bp vec_ready c%0d", k + 1), 64'(vec_ready), 64'(k == 6));
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    #2 chk("bp valid end", 64'(valid_o), 64'd0);
    exp_cnt = (exp_cnt + 1) % 65536;
    chk("bp vec_cnt", 64'(vec_cnt), 64'(exp_cnt));
    @(posedge clk); #1;

    // Reset while idx=2 in SEND
    load_vec(std_w, 3'd4);
    vec_valid = 1'b1;
    @(posedge clk); #1;
    vec_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1 chk("mid idx2 data", 64'(data_o), 64'(std_w[2]));
    rst = 1'b1;
    #1;
    chk("mid rst valid", 64'(valid_o), 64'd0);
    chk("mid rst vec_cnt", 64'(vec_cnt), 64'd0);
    chk("mid rst busy", 64'(busy_o), 64'd0);
    chk("mid rst data", 64'(data_o), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    exp_cnt = 0;
    send_vec("after rst len2", 3'd2,
             '{32'h0000000A, 32'h0000000B, 32'hEEEEEEEE, 32'hEEEEEEEE}, 2);

    // Counter wrap: 65536 one-word vectors from a fresh reset
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    load_vec('{32'h12345678, 32'h0, 32'h0, 32'h0}, 3'd1);
    vec_valid = 1'b1;
    ready_i   = 1'b1;
    repeat (65536) @(posedge clk);
    #1 vec_valid = 1'b0;
    #1;
    chk("wrap vec_cnt pre", 64'(vec_cnt), 64'd65535);
    chk("wrap data", 64'(data_o), 64'h12345678);
    @(posedge clk); #2;
    chk("wrap vec_cnt", 64'(vec_cnt), 64'd0);
    chk("wrap busy", 64'(busy_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/merge_vec_serializer.md
Name: merge_vec_serializer

Overview:
- Upstream feeder for a merge router input port, typically the local port.
- Accepts one vector of VN partial-sum words (IEEE-754 single, DW bits each) from a tile compute/accumulate stage.
- Emits the words one per handshake on a DW-bit valid/ready stream, word 0 first.
- Back-to-back vectors stream with no bubble, so the downstream merge FIFO sees a continuous word stream.

Parameters:
- VN, 8: maximum words per vector; must be >= 2.
- LW, $clog2(VN+1): width of vec_len.
- CW, 16: width of the completed-vector counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- vec_data_i  input  VN*`DW  word i is at bits [i*`DW +: `DW].
- vec_len_i  input  LW  number of words to send. 0 or any value > VN means VN.
- vec_valid_i  input  1  vector present.
- vec_ready_o  output  1  vector accepted when vec_valid_i & vec_ready_o.
- data_o  output  `DW  current word, valid while valid_o is high.
- valid_o  output  1  word present toward the merge router.
- ready_i  input  1  merge router input not full.
- busy_o  output  1  high while in SEND.
- vec_cnt_o  output  CW  count of completed vectors; wraps modulo 2^CW.

Behaviour:
- Reset (asynchronous, effective immediately):
  - state = IDLE, idx = 0, len_q = 0, hold register = 0, vec_cnt_o = 0.
  - valid_o = 0, busy_o = 0, data_o = 0.
  - A vector in flight is discarded with no partial flush.
  - After rst is released, operation resumes at the first rising edge.
- Storage: hold register of VN*`DW bits, len_q (LW+1 bits), idx (LW bits).
- Word handshake: w_hs = valid_o & ready_i. Vector handshake: v_hs = vec_valid_i & vec_ready_o.
- last = (idx == len_q-1).
- vec_ready_o = (state==IDLE) | (w_hs & last). This is a combinational path from ready_i, which is intentional: it gives zero-bubble chaining.
- valid_o = (state==SEND). data_o = hold[idx] when in SEND, otherwise 0.
- IDLE state:
  - On v_hs: capture data into hold, len_q = effective length, idx = 0, go to SEND.
  - First word is valid on the next cycle (latency 1).
- SEND state:
  - w_hs & !last: idx += 1.
  - w_hs & last & v_hs: capture the new vector, idx = 0, stay in SEND, vec_cnt += 1. The next word follows on the next cycle with no bubble.
  - w_hs & last & !v_hs: go to IDLE, vec_cnt += 1.
  - No w_hs: hold all state. data_o and valid_o must stay stable while valid_o & !ready_i (AXI-style rule; valid never drops without a handshake).
- vec_len = 1: single-word vector, where last is true on the first word.
- idx never exceeds len_q-1. Words with index >= len_q are never emitted.
- vec_data_i and vec_len_i are sampled only on v_hs. Changes at any other time have no effect.
- Sustained throughput is 1 word/cycle when ready_i is constantly high.
- The block performs no arithmetic on data. Words pass bit-exact.

Decomposition:
- Shared package merge_pkg holds:
  - typedef enum logic {IDLE, SEND} ser_state_t;
  - the word type logic [`DW-1:0] word_t;
  - a function eff_len(len, VN) implementing the 0/over-range → VN rule.
- `DW stays in params.svh.
- Single module with no sub-module. The word mux is an indexed part-select.

Test Plan (VN=4, DW=32):
1. Reset then one vector, len=4, words 3F800000, 40000000, 40400000, 40800000, ready_i=1 → valid_o high cycles 1-4 with the words in order; vec_cnt_o=1; busy_o low at cycle 5.
2. Two vectors offered back-to-back, len=4 each, ready_i=1 → 8 consecutive valid cycles with no gap; vec_ready_o pulses high in the cycle the 4th word handshakes; vec_cnt_o=2.
3. Backpressure: ready_i=0 on cycles 2-4 of a 4-word send → data_o holds 40000000 and valid_o stays 1 for those cycles; total 7 cycles; no word lost or duplicated.
4. vec_len=0 → 4 words sent. vec_len=1 → only word 0 (3F800000) sent, then IDLE. vec_len=7 → clamped to 4 words.
5. Assert rst while idx=2 in SEND → valid_o=0, vec_cnt_o=0 immediately; next vector (len=2, A, B) emits A, B only.
6. Counter wrap: preload by sending 65536 one-word vectors → vec_cnt_o returns to 0; also change vec_data_i while in SEND → emitted words are unchanged.
